// File: rtl/wb_bridge_down_pipe.sv
// wb_bridge_down_pipe: Wishbone width-down bridge splitting each wide access into narrow per-lane beats (optional WB_BRIDGE_TIMEOUT_EN)
module wb_bridge_down_pipe #(
  parameter int DW_S    = 32,
  parameter int DW_M    = 16,
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_cyc,
  input  logic              s_stb,
  input  logic              s_we,
  input  logic [AW-1:0]     s_adr,
  input  logic [DW_S/8-1:0] s_sel,
  input  logic [DW_S-1:0]   s_dat_i,
  output logic [DW_S-1:0]   s_dat_o,
  output logic              s_ack,
  output logic              s_err,
  output logic              s_rty,
  output logic              m_cyc,
  output logic              m_stb,
  output logic              m_we,
  output logic [AW-1:0]     m_adr,
  output logic [DW_M/8-1:0] m_sel,
  output logic [DW_M-1:0]   m_dat_o,
  input  logic [DW_M-1:0]   m_dat_i,
  input  logic              m_ack,
  input  logic              m_err,
  input  logic              m_rty,
  output logic [2:0]        m_cti,
  output logic [1:0]        m_bte
);
  localparam int R  = DW_S / DW_M;
  localparam int SS = DW_S / 8;
  localparam int MS = DW_M / 8;
  localparam int SB = $clog2(SS);
  localparam int MB = $clog2(MS);
  localparam int LW = $clog2(R);

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  state_t          r_st;
  logic            r_we;
  logic            r_err;
  logic [AW-1:0]   r_adr;
  logic [R-1:0]    r_act;
  logic [SS-1:0]   r_sel;
  logic [DW_S-1:0] r_dat;
  logic [DW_S-1:0] r_rd;
  logic [LW-1:0]   r_lane;
  logic [R-1:0]    w_act;
  logic [DW_S-1:0] w_lmask;
  int              w_first;
  int              w_nxt;
`ifdef WB_BRIDGE_TIMEOUT_EN
  logic [15:0]     r_cnt;
`else
  localparam int unused_timeout = TIMEOUT;
`endif

  function automatic int f_next(input logic [R-1:0] a, input int l);
    f_next = R;
    for (int i = R - 1; i >= 0; i--) if (a[i] && i > l) f_next = i;
  endfunction

  function automatic logic [2:0] f_cti(input logic [R-1:0] a, input int l);
    int n;
    n = f_next(a, l);
    f_cti = ($countones(a) == 1) ? 3'b000 : (n == R) ? 3'b111 : (n == l + 1) ? 3'b010 : 3'b000;
  endfunction

  function automatic logic [AW-1:0] f_adr(input logic [AW-1:0] a, input int l);
    f_adr = ((a >> SB) << SB) | (AW'(l) << MB);
  endfunction

  for (genvar i = 0; i < R; i++) begin : g_lane
    assign w_act[i] = |s_sel[i*MS +: MS];
    assign w_lmask[i*DW_M +: DW_M] = {DW_M{r_act[i]}};
  end

  assign s_rty = 1'b0;
  assign m_bte = 2'b00;

  // lowest active lane of a new request and next active lane above the current one
  always_comb begin
    w_first = f_next(w_act, -1);
    w_nxt   = f_next(r_act, int'(r_lane));
  end

  // request latch, per-lane beat sequencing and slave termination
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st    <= IDLE;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_adr   <= '0;
      r_act   <= '0;
      r_sel   <= '0;
      r_dat   <= '0;
      r_rd    <= '0;
      r_lane  <= '0;
      s_dat_o <= '0;
      s_ack   <= 1'b0;
      s_err   <= 1'b0;
      m_cyc   <= 1'b0;
      m_stb   <= 1'b0;
      m_we    <= 1'b0;
      m_adr   <= '0;
      m_sel   <= '0;
      m_dat_o <= '0;
      m_cti   <= 3'b000;
`ifdef WB_BRIDGE_TIMEOUT_EN
      r_cnt   <= '0;
`endif
    end else begin
      s_ack   <= 1'b0;
      s_err   <= 1'b0;
      s_dat_o <= '0;
      case (r_st)
        IDLE: if (s_cyc && s_stb) begin
          r_we  <= s_we;
          r_adr <= s_adr;
          r_act <= w_act;
          r_sel <= s_sel;
          r_dat <= s_dat_i;
          r_rd  <= '0;
          r_err <= 1'b0;
          if (w_act == '0) r_st <= RESP;
          else begin
            r_st    <= XFER;
            r_lane  <= LW'(w_first);
            m_cyc   <= 1'b1;
            m_stb   <= 1'b1;
            m_we    <= s_we;
            m_adr   <= f_adr(s_adr, w_first);
            m_sel   <= s_sel[w_first*MS +: MS];
            m_dat_o <= s_dat_i[w_first*DW_M +: DW_M];
            m_cti   <= f_cti(w_act, w_first);
`ifdef WB_BRIDGE_TIMEOUT_EN
            r_cnt   <= '0;
`endif
          end
        end
        XFER: if (!s_cyc) begin
          m_cyc <= 1'b0;
          m_stb <= 1'b0;
          r_st  <= IDLE;
        end else if (m_err || m_rty) begin
          m_cyc <= 1'b0;
          m_stb <= 1'b0;
          r_err <= 1'b1;
          r_st  <= RESP;
        end else if (m_ack) begin
          if (!r_we) r_rd[int'(r_lane)*DW_M +: DW_M] <= m_dat_i;
          if (w_nxt < R) begin
            r_lane  <= LW'(w_nxt);
            m_adr   <= f_adr(r_adr, w_nxt);
            m_sel   <= r_sel[w_nxt*MS +: MS];
            m_dat_o <= r_dat[w_nxt*DW_M +: DW_M];
            m_cti   <= f_cti(r_act, w_nxt);
`ifdef WB_BRIDGE_TIMEOUT_EN
            r_cnt   <= '0;
`endif
          end else begin
            m_cyc <= 1'b0;
            m_stb <= 1'b0;
            r_st  <= RESP;
          end
        end
`ifdef WB_BRIDGE_TIMEOUT_EN
        else if (r_cnt == 16'(TIMEOUT - 1)) begin
          m_cyc <= 1'b0;
          m_stb <= 1'b0;
          s_err <= 1'b1;
          r_st  <= IDLE;
        end else r_cnt <= r_cnt + 16'd1;
`endif
        RESP: begin
          s_ack   <= !r_err;
          s_err   <= r_err;
          s_dat_o <= r_rd & w_lmask;
          r_st    <= IDLE;
        end
        default: r_st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_bridge_down_pipe.sv
// tb_wb_bridge_down_pipe: vector table, hand sequences and random traffic against a lane-list reference model
module tb_wb_bridge_down_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_cyc = 1'b0, s_stb = 1'b0, s_we = 1'b0;
  logic [31:0] s_adr = '0;
  logic [7:0]  s_sel = '0;
  logic [63:0] s_dat_i = '0;
  logic [63:0] s_dat_o;
  logic        s_ack, s_err, s_rty;
  logic        m_cyc, m_stb, m_we;
  logic [31:0] m_adr;
  logic [1:0]  m_sel;
  logic [15:0] m_dat_o;
  logic [15:0] m_dat_i = '0;
  logic        m_ack = 1'b0, m_err = 1'b0, m_rty = 1'b0;
  logic [2:0]  m_cti;
  logic [1:0]  m_bte;

  wb_bridge_down_pipe #(.DW_S(64), .DW_M(16), .AW(32), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_sel(s_sel),
    .s_dat_i(s_dat_i), .s_dat_o(s_dat_o), .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_sel(m_sel),
    .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_ack(m_ack), .m_err(m_err), .m_rty(m_rty),
    .m_cti(m_cti), .m_bte(m_bte)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] adr;
    logic [1:0]  sel;
    logic [15:0] dat;
    logic        we;
    logic [2:0]  cti;
  } beat_t;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [7:0]  sel;
    logic [63:0] dat;
    int          wt;
    int          eb;
    logic        rty;
    int          exp_lat;
    int          exp_n;
    logic        exp_err;
  } vec_t;

  int    checks = 0;
  int    failures = 0;
  int    g_wait = 0;
  int    g_eb = -1;
  logic  g_rty = 1'b0;
  int    wc = 0;
  int    nbeat = 0;
  beat_t bq[$];
  beat_t eq[$];
  int    m_lat;
  int    m_n;
  logic  m_errx;
  logic [63:0] m_rd;

  function automatic logic [15:0] f_rd(input logic [31:0] a);
    f_rd = a[15:0] ^ 16'hC3A5;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // narrow slave: acks each beat after g_wait idle cycles, errors/retries on beat g_eb
  always @(negedge clk) begin
    if (m_cyc && m_stb) begin
      if (wc == g_wait) begin
        beat_t b;
        wc = 0;
        b.adr = m_adr; b.sel = m_sel; b.dat = m_dat_o; b.we = m_we; b.cti = m_cti;
        bq.push_back(b);
        m_dat_i = f_rd(m_adr);
        if (nbeat == g_eb) begin m_ack = 1'b0; m_err = !g_rty; m_rty = g_rty; end
        else begin m_ack = 1'b1; m_err = 1'b0; m_rty = 1'b0; end
        nbeat++;
      end else begin
        wc++;
        m_ack = 1'b0; m_err = 1'b0; m_rty = 1'b0;
      end
    end else begin
      wc = 0;
      m_ack = 1'b0; m_err = 1'b0; m_rty = 1'b0;
    end
  end

  // reference: list active lanes, one beat each, burst codes from lane adjacency
  task automatic model(input vec_t v);
    int ln[$];
    int nb;
    int k;
    beat_t b;
    eq.delete();
    m_rd = '0;
    for (int i = 0; i < 4; i++) if (v.sel[i*2 +: 2] != 2'b00) ln.push_back(i);
    k = v.wt + 1;
    if (v.eb >= 0 && v.eb < ln.size()) begin nb = v.eb + 1; m_errx = 1'b1; end
    else begin nb = ln.size(); m_errx = 1'b0; end
    m_n = nb;
    m_lat = 1 + nb * k + 1;
    for (int j = 0; j < nb; j++) begin
      b.adr = (v.adr & 32'hFFFF_FFF8) + 32'(ln[j] * 2);
      b.sel = v.sel[ln[j]*2 +: 2];
      b.dat = v.dat[ln[j]*16 +: 16];
      b.we  = v.we;
      b.cti = (ln.size() == 1) ? 3'b000 : (j == ln.size() - 1) ? 3'b111 : (ln[j+1] == ln[j] + 1) ? 3'b010 : 3'b000;
      eq.push_back(b);
    end
    foreach (ln[j]) m_rd[ln[j]*16 +: 16] = f_rd((v.adr & 32'hFFFF_FFF8) + 32'(ln[j] * 2));
  endtask

  task automatic run(input vec_t v, input logic use_tbl);
    int lat;
    logic got_ack, got_err;
    logic [63:0] rd;
    model(v);
    @(negedge clk);
    g_wait = v.wt; g_eb = v.eb; g_rty = v.rty; nbeat = 0; bq.delete();
    s_cyc = 1'b1; s_stb = 1'b1; s_we = v.we; s_adr = v.adr; s_sel = v.sel; s_dat_i = v.dat;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!(s_ack || s_err) && lat < 200);
    got_ack = s_ack; got_err = s_err; rd = s_dat_o;
    s_cyc = 1'b0; s_stb = 1'b0;
    chk("latency", lat, use_tbl ? v.exp_lat : m_lat);
    chk("s_ack", got_ack, use_tbl ? !v.exp_err : !m_errx);
    chk("s_err", got_err, use_tbl ? v.exp_err : m_errx);
    chk("s_rty", s_rty, 0);
    if (!v.we && !m_errx) chk("s_dat_o", rd, m_rd);
    @(posedge clk); #1;
    chk("term_pulse", {s_ack, s_err}, 0);
    chk("m_cyc_idle", m_cyc, 0);
    chk("nbeats", bq.size(), use_tbl ? v.exp_n : m_n);
    for (int j = 0; j < bq.size() && j < eq.size(); j++) begin
      chk("beat_adr", bq[j].adr, eq[j].adr);
      chk("beat_sel", bq[j].sel, eq[j].sel);
      chk("beat_we", bq[j].we, eq[j].we);
      chk("beat_cti", bq[j].cti, eq[j].cti);
      if (v.we) chk("beat_dat", bq[j].dat, eq[j].dat);
    end
  endtask

  vec_t tbl[10];

  initial begin
    vec_t v;
    logic seen;
    int n;
    logic [3:0] pat;
    tbl[0] = '{1'b1, 32'h100, 8'h0F, 64'h0000_0000_A5A5_5A5A, 0, -1, 1'b0, 4, 2, 1'b0};
    tbl[1] = '{1'b0, 32'h100, 8'h0C, 64'h0,                   0, -1, 1'b0, 3, 1, 1'b0};
    tbl[2] = '{1'b0, 32'h200, 8'hC3, 64'h0,                   0, -1, 1'b0, 4, 2, 1'b0};
    tbl[3] = '{1'b1, 32'h300, 8'hFF, 64'h1111_2222_3333_4444, 0,  2, 1'b0, 5, 3, 1'b1};
    tbl[4] = '{1'b0, 32'h400, 8'h00, 64'h0,                   0, -1, 1'b0, 2, 0, 1'b0};
    tbl[5] = '{1'b0, 32'h500, 8'hCF, 64'h0,                   1, -1, 1'b0, 8, 3, 1'b0};
    tbl[6] = '{1'b0, 32'h1FB, 8'h3C, 64'h0,                   0, -1, 1'b0, 4, 2, 1'b0};
    tbl[7] = '{1'b1, 32'h600, 8'h80, 64'hDEAD_0000_0000_0000, 0, -1, 1'b0, 3, 1, 1'b0};
    tbl[8] = '{1'b0, 32'h700, 8'hF0, 64'h0,                   2,  0, 1'b1, 5, 1, 1'b1};
    tbl[9] = '{1'b1, 32'h800, 8'h01, 64'h0000_0000_0000_BEEF, 3, -1, 1'b0, 6, 1, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_cyc", m_cyc, 0);
    chk("rst_m_stb", m_stb, 0);
    chk("rst_s_ack", {s_ack, s_err}, 0);
    chk("rst_m_adr", m_adr, 0);
    chk("rst_m_cti", {m_cti, m_bte}, 0);
    chk("rst_s_dat_o", s_dat_o, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) run(tbl[i], 1'b1);

    // abort during the second beat while the narrow slave acks it
    @(negedge clk);
    g_wait = 0; g_eb = -1; nbeat = 0; bq.delete();
    s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b0; s_adr = 32'h900; s_sel = 8'hFF;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (nbeat < 1 && n < 20);
    s_cyc = 1'b0; s_stb = 1'b0;
    @(posedge clk); #1;
    chk("abort_m_cyc", {m_cyc, m_stb}, 0);
    seen = 1'b0;
    repeat (6) begin @(posedge clk); #1; seen = seen | s_ack | s_err | m_cyc; end
    chk("abort_noterm", seen, 0);

    // reset in the middle of a transfer
    @(negedge clk);
    g_wait = 5; g_eb = -1; nbeat = 0; bq.delete();
    s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b0; s_adr = 32'hA00; s_sel = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_m_cyc", m_cyc, 1);
    @(negedge clk);
    rst = 1'b1; s_cyc = 1'b0; s_stb = 1'b0;
    @(posedge clk); #1;
    chk("midrst_m_cyc", {m_cyc, m_stb}, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin @(posedge clk); #1; seen = seen | s_ack | s_err | m_cyc; end
    chk("midrst_noterm", seen, 0);

    // request held past the acknowledge starts a fresh access
    @(negedge clk);
    g_wait = 0; g_eb = -1; nbeat = 0; bq.delete();
    s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b0; s_adr = 32'hB00; s_sel = 8'h00;
    pat = 4'b1010;
    for (int e = 0; e < 4; e++) begin
      @(posedge clk); #1;
      chk("b2b_ack", s_ack, pat[e]);
    end
    s_cyc = 1'b0; s_stb = 1'b0;
    @(posedge clk); #1;
    chk("b2b_end", s_ack, 0);

    for (int t = 0; t < 60; t++) begin
      v.we  = 1'($urandom_range(0, 1));
      v.adr = $urandom;
      v.sel = 8'($urandom_range(0, 255));
      v.dat = {$urandom, $urandom};
      v.wt  = $urandom_range(0, 2);
      v.eb  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      v.rty = 1'($urandom_range(0, 1));
      v.exp_lat = 0; v.exp_n = 0; v.exp_err = 1'b0;
      run(v, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
